// File: rtl/card_shuffler.sv
// card_shuffler: builds a shuffled layout of colour pairs and streams it into card memory.
// Define CARD_SHUFFLE_BYPASS_EN to skip the shuffle and emit the deterministic layout slot k = pair k>>1.
module card_shuffler #(
    parameter int          ADDR_W    = 5,
    parameter int          COLOR_W   = 12,
    parameter int          NUM_W     = 6,
    parameter int          MAX_CARDS = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compute_colors_en,
    input  logic [NUM_W-1:0]   num_of_cards,
    output logic               compute_done,
    output logic               card_wr_en,
    output logic [ADDR_W-1:0]  card_wr_addr,
    output logic [COLOR_W-1:0] card_wr_color,
    output logic [1:0]         card_wr_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL    = 3'd1;
    localparam logic [2:0] ST_SHUFFLE = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]        state_reg;
    logic [15:0]       lfsr_reg;
    logic              lfsr_fb;
    logic [NUM_W-1:0]  n_reg;
    logic [NUM_W-1:0]  idx_reg;
    logic [NUM_W-1:0]  n_req;
    logic [3:0]        slot_reg [MAX_CARDS];
    logic [ADDR_W-1:0] slot_idx;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] j_val;
    logic              fill_we;
    logic              swap_we;
    logic              last_idx;

    // Pairwise distinct, non-zero RGB444 colours.
    function automatic logic [COLOR_W-1:0] palette_lookup(input logic [3:0] pair);
        logic [11:0] rgb;
        case (pair)
            4'd0:  rgb = 12'hF00;
            4'd1:  rgb = 12'h0F0;
            4'd2:  rgb = 12'h00F;
            4'd3:  rgb = 12'hFF0;
            4'd4:  rgb = 12'h0FF;
            4'd5:  rgb = 12'hF0F;
            4'd6:  rgb = 12'hFFF;
            4'd7:  rgb = 12'hF80;
            4'd8:  rgb = 12'h8F0;
            4'd9:  rgb = 12'h08F;
            4'd10: rgb = 12'h80F;
            4'd11: rgb = 12'hF08;
            4'd12: rgb = 12'h0F8;
            4'd13: rgb = 12'h888;
            4'd14: rgb = 12'h840;
            default: rgb = 12'h48C;
        endcase
        return COLOR_W'(rgb);
    endfunction

    assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign slot_idx = idx_reg[ADDR_W-1:0];
    assign last_idx = (idx_reg == n_reg - NUM_W'(1));

    always_comb begin
        n_req = (num_of_cards > NUM_W'(MAX_CARDS)) ? NUM_W'(MAX_CARDS) : num_of_cards;
        n_req[0] = 1'b0;
    end

    // Smallest all-ones mask covering i: OR together every right shift of i.
    always_comb begin
        mask = slot_idx;
        for (int s = 1; s < ADDR_W; s++) begin
            mask = mask | (slot_idx >> s);
        end
    end

    assign j_val   = lfsr_reg[ADDR_W-1:0] & mask;
    assign fill_we = (state_reg == ST_FILL) && compute_colors_en;
    assign swap_we = (state_reg == ST_SHUFFLE) && compute_colors_en &&
                     (idx_reg != '0) && (NUM_W'(j_val) <= idx_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MAX_CARDS; s++) begin
                slot_reg[s] <= '0;
            end
        end else if (fill_we) begin
            slot_reg[slot_idx] <= 4'(idx_reg >> 1);
        end else if (swap_we) begin
            slot_reg[slot_idx] <= slot_reg[j_val];
            slot_reg[j_val]    <= slot_reg[slot_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lfsr_reg      <= LFSR_SEED;
            n_reg         <= '0;
            idx_reg       <= '0;
            compute_done  <= 1'b0;
            card_wr_en    <= 1'b0;
            card_wr_addr  <= '0;
            card_wr_color <= '0;
            card_wr_state <= 2'b00;
        end else begin
            lfsr_reg      <= {lfsr_reg[14:0], lfsr_fb};
            compute_done  <= 1'b0;
            card_wr_en    <= 1'b0;
            card_wr_addr  <= '0;
            card_wr_color <= '0;
            card_wr_state <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (compute_colors_en) begin
                        n_reg     <= n_req;
                        idx_reg   <= '0;
                        state_reg <= (n_req == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!compute_colors_en) begin
                        state_reg <= ST_IDLE;
                    end else if (last_idx) begin
`ifdef CARD_SHUFFLE_BYPASS_EN
                        state_reg <= ST_WRITE;
                        idx_reg   <= '0;
`else
                        state_reg <= ST_SHUFFLE;
`endif
                    end else begin
                        idx_reg <= idx_reg + NUM_W'(1);
                    end
                end
                ST_SHUFFLE: begin
                    // A rejected draw keeps i and retries with the next LFSR value.
                    if (!compute_colors_en) begin
                        state_reg <= ST_IDLE;
                    end else if (idx_reg == '0) begin
                        state_reg <= ST_WRITE;
                    end else if (swap_we) begin
                        idx_reg <= idx_reg - NUM_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (!compute_colors_en) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        card_wr_en    <= 1'b1;
                        card_wr_addr  <= slot_idx;
                        card_wr_color <= palette_lookup(slot_reg[slot_idx]);
                        card_wr_state <= 2'b01;
                        idx_reg       <= idx_reg + NUM_W'(1);
                        if (last_idx) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (compute_colors_en) begin
                        compute_done <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
